instr_fetch_ctrl: RTL

Instruction fetch controller that sequences the instruction memory for the processor front end. Holds the program counter, drives the memory address, waits a fixed number of clocks for the memory's access delay, then presents the fetched word and its PC to decode with a valid/ready handshake. Sits between the PC/branch logic and the instruction memory; branch and jump targets enter through a redirect port.

---
 rtl/instr_fetch_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: holds the PC, waits WAIT_CYCLES for memory, then hands the word
// to decode over valid/ready. Optional bounds checking is enabled by defining IFETCH_BOUNDS_EN.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned MEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {StWait, StHold, StFault} state_e;

    localparam logic [7:0] CntLast = 8'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fpc_q, fpc_d;
    logic        enter_wait;

`ifdef IFETCH_BOUNDS_EN
    localparam logic [32:0] BoundLimit = 33'(MEM_WORDS) << 2;
    localparam logic        ResetOut   = ({1'b0, RESET_PC} >= BoundLimit);

    logic fault_q, fault_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        fpc_d      = fpc_q;
        enter_wait = 1'b0;
`ifdef IFETCH_BOUNDS_EN
        fault_d    = fault_q;
`endif
        if (redirect) begin
            // Redirect wins over a simultaneous handshake; the held word is simply dropped.
            pc_d       = {redirect_pc[31:2], 2'b00};
            valid_d    = 1'b0;
            cnt_d      = 8'd0;
            enter_wait = 1'b1;
`ifdef IFETCH_BOUNDS_EN
            fault_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StWait: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CntLast) begin
                        instr_d = instruction;
                        fpc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (fetch_ready) begin
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b0;
                        cnt_d      = 8'd0;
                        enter_wait = 1'b1;
                    end
                end
                StFault: ;
                default: state_d = StWait;
            endcase
        end

        if (enter_wait) begin
            state_d = StWait;
`ifdef IFETCH_BOUNDS_EN
            if ({1'b0, pc_d} >= BoundLimit) begin
                state_d = StFault;
                fault_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef IFETCH_BOUNDS_EN
            state_q <= ResetOut ? StFault : StWait;
            fault_q <= ResetOut;
`else
            state_q <= StWait;
`endif
            cnt_q   <= 8'd0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            fpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
`ifdef IFETCH_BOUNDS_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign mem_addr    = pc_q;
    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
    assign fetch_pc    = fpc_q;
`ifdef IFETCH_BOUNDS_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
